mxv_result_writer: RTL and testbench

//  Write-side counterpart to the matrix-by-vector read path. Captures each
//  mXv1_result word when the multiplier strobes outsider_read_now, buffers it
//  in a small FIFO, and writes it to the result memory at sequential addresses.

---
 rtl/mxv_result_writer.sv | 158 +++++++++++++++
 tb/tb_mxv_result_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mxv_result_writer.sv
// Result write-back for the matrix-by-vector path: FIFO-buffers result words and
// writes them to sequential addresses. Define MXV_WRITER_SERIAL_EN for per-element writes.
module mxv_result_writer #(
    parameter int element_width          = 32,
    parameter int no_of_units            = 8,
    parameter int memories_address_width = 32,
    parameter int fifo_depth             = 4,
    parameter int fifo_addr_width        = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [31:0]                              total_results,
    input  logic [no_of_units*element_width-1:0]     result_in,
    input  logic                                     result_valid,
    output logic                                     mem_write_enable,
    output logic [memories_address_width-1:0]        mem_write_address,
`ifdef MXV_WRITER_SERIAL_EN
    output logic [element_width-1:0]                 mem_write_data,
`else
    output logic [no_of_units*element_width-1:0]     mem_write_data,
`endif
    output logic                                     busy,
    output logic                                     done,
    output logic                                     overflow,
    output logic [fifo_addr_width:0]                 fifo_level
);

    localparam int RW = no_of_units * element_width;
    localparam int AW = memories_address_width;
    localparam logic [fifo_addr_width:0] FULL_LVL = (fifo_addr_width+1)'(fifo_depth);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [31:0]                total, count;
    logic [RW-1:0]              fifo_mem [fifo_depth];
    logic [fifo_addr_width-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0]              next_addr;
    logic [RW-1:0]              head;
    logic                       push_req, push, pop, full, empty;
    logic                       start_ok, last_push, writer_free;

    assign full      = (fifo_level == FULL_LVL);
    assign empty     = (fifo_level == '0);
    assign push_req  = (state == COLLECT) && result_valid;
    assign push      = push_req && !full;
    assign pop       = !empty && writer_free;
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign last_push = push_req && (count + 32'd1 == total);
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state == COLLECT) || (state == DRAIN);
    assign done      = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (total_results == 32'd0) ? DONE : COLLECT;
            COLLECT:    if (last_push) state_nxt = DRAIN;
            DRAIN:      if (empty && writer_free) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Dropped words still count toward the total so a run always terminates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (start_ok) begin
            total    <= total_results;
            count    <= '0;
            overflow <= 1'b0;
        end else if (push_req) begin
            count <= count + 32'd1;
            if (full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= result_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + fifo_addr_width'(1);
            if (pop)  rd_ptr <= rd_ptr + fifo_addr_width'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (fifo_addr_width+1)'(1);
                2'b01:   fifo_level <= fifo_level - (fifo_addr_width+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

`ifdef MXV_WRITER_SERIAL_EN
    localparam int CW = $clog2(no_of_units + 1);

    logic [CW-1:0] remaining;
    logic [RW-1:0] shreg;
    logic          fire;

    assign writer_free = (remaining == '0);
    assign fire        = pop || (remaining != '0);

    // Most significant element goes out first; shreg holds the elements still pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining      <= '0;
            shreg          <= '0;
            mem_write_data <= '0;
        end else if (pop) begin
            mem_write_data <= head[RW-1 -: element_width];
            shreg          <= head << element_width;
            remaining      <= CW'(no_of_units - 1);
        end else if (remaining != '0) begin
            mem_write_data <= shreg[RW-1 -: element_width];
            shreg          <= shreg << element_width;
            remaining      <= remaining - CW'(1);
        end
    end
`else
    logic fire;

    assign writer_free = 1'b1;
    assign fire        = pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    mem_write_data <= '0;
        else if (pop) mem_write_data <= head;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            next_addr         <= '0;
        end else begin
            mem_write_enable <= fire;
            if (fire) mem_write_address <= next_addr;
            if (start_ok)  next_addr <= '0;
            else if (fire) next_addr <= next_addr + AW'(1);
        end
    end

endmodule

// File: tb/tb_mxv_result_writer.sv
// Scoreboard bench for mxv_result_writer: expected writes are queued as results are
// driven and checked as the write strobes appear. Honours MXV_WRITER_SERIAL_EN.
module tb_mxv_result_writer;

    localparam int EW = 32;
    localparam int NI = 8;
    localparam int AW = 32;
    localparam int RW = NI * EW;
`ifdef MXV_WRITER_SERIAL_EN
    localparam int DW = EW;
`else
    localparam int DW = RW;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset, start, result_valid;
    logic [31:0]   total_results;
    logic [RW-1:0] result_in;
    logic          mem_write_enable, busy, done, overflow;
    logic [AW-1:0] mem_write_address;
    logic [DW-1:0] mem_write_data;
    logic [2:0]    fifo_level;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    bit            mon_en;
    wr_t           sb[$];
    int            wr_log[$];
    logic [AW-1:0] exp_addr;

    mxv_result_writer dut (
        .clk(clk), .reset(reset), .start(start), .total_results(total_results),
        .result_in(result_in), .result_valid(result_valid),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .busy(busy), .done(done),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && mon_en && mem_write_enable) begin
            wr_log.push_back(cyc);
            if (sb.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", mem_write_address, e.addr);
                chk("wr_data", mem_write_data, e.data);
            end
        end
    end

    function automatic logic [RW-1:0] mkw(input logic [7:0] t);
        logic [RW-1:0] r;
        for (int k = 0; k < NI; k++) r[k*EW +: EW] = {8'(k), 16'hC0DE, t};
        return r;
    endfunction

    task automatic push_exp(input logic [RW-1:0] w);
`ifdef MXV_WRITER_SERIAL_EN
        for (int k = 0; k < NI; k++) begin
            sb.push_back('{exp_addr, w[RW-1-k*EW -: EW]});
            exp_addr++;
        end
`else
        sb.push_back('{exp_addr, w});
        exp_addr++;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] t);
        start = 1'b1;
        total_results = t;
        exp_addr = '0;
        idle(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [RW-1:0] w, input bit expect_wr);
        result_valid = 1'b1;
        result_in = w;
        if (expect_wr) push_exp(w);
        idle(1);
        result_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, done, 1);
        if (wr_log.size() > 0) chk({tag, "_done_gap"}, cyc - wr_log[$], 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset = 1'b1; start = 1'b0; total_results = '0; result_in = '0;
        result_valid = 1'b0; mon_en = 1'b1; exp_addr = '0;
        idle(3);
        chk("rst_we", mem_write_enable, 0);
        chk("rst_addr", mem_write_address, 0);
        chk("rst_data", mem_write_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_lvl", fifo_level, 0);
        reset = 1'b0;
        idle(1);

        // valid strobes in IDLE are ignored
        for (int i = 0; i < 3; i++) send(mkw(8'h55), 1'b0);
        idle(3);
        chk("idle_lvl", fifo_level, 0);
        chk("idle_busy", busy, 0);

        // zero-length run
        do_start(32'd0);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        idle(3);
        chk("zero_busy_hold", busy, 0);
        chk("zero_done_hold", done, 1);

        // three words, spaced five cycles apart
        do_start(32'd3);
        chk("t1_busy", busy, 1);
        chk("t1_done_clr", done, 0);
        send(mkw(8'hA1), 1'b1);
        idle(4);
        send(mkw(8'hB2), 1'b1);
        idle(4);
        send(mkw(8'hC3), 1'b1);
        wait_done("t1");
        chk("t1_ovf", overflow, 0);

        // start during COLLECT and valid during DRAIN are ignored
        do_start(32'd2);
        send(mkw(8'h21), 1'b1);
        start = 1'b1; total_results = 32'd9;
        idle(1);
        start = 1'b0;
        send(mkw(8'h22), 1'b1);
        send(mkw(8'h23), 1'b0);
        wait_done("t5");

`ifdef MXV_WRITER_SERIAL_EN
        // six back-to-back words: the sixth finds the FIFO full
        do_start(32'd6);
        c0 = wr_log.size();
        for (int i = 0; i < 6; i++) send(mkw(8'h60 + 8'(i)), i < 5);
        wait_done("t2");
        chk("t2_ovf", overflow, 1);
        chk("t2_nwr", wr_log.size() - c0, 40);
`else
        // valid every cycle: one write per cycle, FIFO never above one entry
        do_start(32'd4);
        c0 = wr_log.size();
        for (int i = 0; i < 4; i++) begin
            send(mkw(8'h40 + 8'(i)), 1'b1);
            chk("t6_lvl", fifo_level <= 3'd1, 1);
        end
        wait_done("t6");
        chk("t6_nwr", wr_log.size() - c0, 4);
        if (wr_log.size() - c0 == 4) chk("t6_span", wr_log[$] - wr_log[c0], 3);
        chk("t6_ovf", overflow, 0);
`endif

        // reset in DRAIN with words still queued
        do_start(32'd3);
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) send(mkw(8'h70 + 8'(i)), 1'b0);
        chk("t4_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        chk("t4_we", mem_write_enable, 0);
        chk("t4_addr", mem_write_address, 0);
        chk("t4_data", mem_write_data, 0);
        chk("t4_busy", busy, 0);
        chk("t4_lvl", fifo_level, 0);
        chk("t4_ovf", overflow, 0);
        idle(2);
        reset = 1'b0;
        sb.delete();
        mon_en = 1'b1;
        idle(1);
        do_start(32'd1);
        send(mkw(8'h99), 1'b1);
        wait_done("t4_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
